// File: rtl/conway_board_sequencer.sv
// ---------------------------------------------------------------------------
// conway_board_sequencer
//
// Generation controller for an array of conway_cell instances. It drives the
// shared cell reset/enable lines that every cell sees:
//   - LOAD holds cell_rst high for LOAD_CYCLES cycles, so every cell latches
//     its seed state.
//   - STEP issues exactly one cell_ena strobe, which advances one generation.
//   - RUN issues one strobe every TICK_DIV cycles. It stops after cmd_count
//     generations, on PAUSE/LOAD, or, when STOP_ON_STABLE is set, on a
//     generation in which no cell changed.
// Commands arrive over a valid/ready handshake.
//
// Ports
//   clk            in   system clock, all state on its rising edge
//   rst_n          in   asynchronous active-low reset
//   cmd_valid      in   command present
//   cmd_ready      out  command is taken when cmd_valid & cmd_ready at posedge
//   cmd_op         in   00 LOAD, 01 STEP, 10 RUN, 11 PAUSE
//   cmd_count      in   RUN length in generations; 0 = unbounded
//   board_changed  in   OR over all cells of (next state != current state)
//   cell_rst       out  to every cell's rst (registered)
//   cell_ena       out  to every cell's ena; one high cycle = one generation
//   busy           out  sequencer not idle
//   generation     out  generations since the last LOAD, saturating
//   stable         out  the last strobe saw board_changed = 0
//   done           out  one-cycle pulse when STEP/RUN finishes by itself
// ---------------------------------------------------------------------------
module conway_board_sequencer #(
    parameter int TICK_DIV       = 4,
    parameter int GEN_W          = 16,
    parameter int LOAD_CYCLES    = 2,
    parameter int STOP_ON_STABLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [GEN_W-1:0] cmd_count,
    input  logic             board_changed,
    output logic             cell_rst,
    output logic             cell_ena,
    output logic             busy,
    output logic [GEN_W-1:0] generation,
    output logic             stable,
    output logic             done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);
    localparam logic [GEN_W-1:0]  GEN_MAX   = {GEN_W{1'b1}};
    localparam logic [GEN_W-1:0]  GEN_ONE   = GEN_W'(1);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_PAUSE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_STEP = 2'b10,
        ST_RUN  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
    logic [GEN_W-1:0]  remaining_q, remaining_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic              stable_q, stable_d;
    logic              done_q, done_d;
    logic              cell_rst_q, cell_rst_d;
    // Low only until the first edge after reset release. Keeps cmd_ready low
    // during reset even though the state register already reads IDLE.
    logic              live_q;

    logic accept;
    logic strobe;
    logic load_go;

    // Moore outputs. The strobe depends only on state/tick, so a PAUSE or
    // LOAD accepted in a strobe cycle does not cancel that generation.
    assign cmd_ready  = live_q && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    assign accept     = cmd_valid && cmd_ready;
    assign strobe     = (state_q == ST_STEP) ||
                        ((state_q == ST_RUN) && (tick_q == TICK_LAST));
    assign cell_ena   = strobe;
    assign cell_rst   = cell_rst_q;
    assign busy       = (state_q != ST_IDLE);
    assign generation = gen_q;
    assign stable     = stable_q;
    assign done       = done_q;

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        load_cnt_d  = load_cnt_q;
        remaining_d = remaining_q;
        gen_d       = gen_q;
        stable_d    = stable_q;
        done_d      = 1'b0;
        load_go     = 1'b0;

        if (strobe) begin
            gen_d    = (gen_q == GEN_MAX) ? gen_q : gen_q + GEN_ONE;
            stable_d = ~board_changed;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD: load_go = 1'b1;
                        OP_STEP: state_d = ST_STEP;
                        OP_RUN: begin
                            state_d     = ST_RUN;
                            tick_d      = '0;
                            remaining_d = cmd_count;
                        end
                        default: ;  // PAUSE while idle is a no-op
                    endcase
                end
            end
            ST_LOAD: begin
                if (load_cnt_q == LOAD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    load_cnt_d = load_cnt_q + LOAD_W'(1);
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            ST_RUN: begin
                tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
                if (strobe) begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - GEN_ONE;
                    end
                    // A count of 0 never matches 1, so it runs until stopped.
                    if ((remaining_q == GEN_ONE) ||
                        ((STOP_ON_STABLE != 0) && !board_changed)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                // A host abort overrides a natural finish in the same cycle.
                if (accept) begin
                    if (cmd_op == OP_PAUSE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b0;
                    end else if (cmd_op == OP_LOAD) begin
                        load_go = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // LOAD restarts the generation history. It wins over a strobe
        // increment in the same cycle.
        if (load_go) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
            gen_d      = '0;
            stable_d   = 1'b0;
            done_d     = 1'b0;
        end

        cell_rst_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            load_cnt_q  <= '0;
            remaining_q <= '0;
            gen_q       <= '0;
            stable_q    <= 1'b0;
            done_q      <= 1'b0;
            cell_rst_q  <= 1'b1;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            load_cnt_q  <= load_cnt_d;
            remaining_q <= remaining_d;
            gen_q       <= gen_d;
            stable_q    <= stable_d;
            done_q      <= done_d;
            cell_rst_q  <= cell_rst_d;
            live_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conway_board_sequencer.sv
module tb_conway_board_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int GEN_W       = 16;
    localparam int LOAD_CYCLES = 2;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [GEN_W-1:0] cmd_count;
    logic             board_changed;
    logic             cell_rst;
    logic             cell_ena;
    logic             busy;
    logic [GEN_W-1:0] generation;
    logic             stable;
    logic             done;

    // Small instance for generation saturation: GEN_W=2, strobe every cycle.
    logic       s_cmd_valid;
    logic       s_cmd_ready;
    logic [1:0] s_cmd_op;
    logic [1:0] s_cmd_count;
    logic       s_board_changed;
    logic       s_cell_rst;
    logic       s_cell_ena;
    logic       s_busy;
    logic [1:0] s_generation;
    logic       s_stable;
    logic       s_done;

    conway_board_sequencer #(
        .TICK_DIV(TICK_DIV), .GEN_W(GEN_W), .LOAD_CYCLES(LOAD_CYCLES), .STOP_ON_STABLE(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .board_changed(board_changed),
        .cell_rst(cell_rst), .cell_ena(cell_ena), .busy(busy),
        .generation(generation), .stable(stable), .done(done)
    );

    conway_board_sequencer #(
        .TICK_DIV(1), .GEN_W(2), .LOAD_CYCLES(1), .STOP_ON_STABLE(1)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_op(s_cmd_op), .cmd_count(s_cmd_count), .board_changed(s_board_changed),
        .cell_rst(s_cell_rst), .cell_ena(s_cell_ena), .busy(s_busy),
        .generation(s_generation), .stable(s_stable), .done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        int         count;
        int         zero_at;      // strobe index at which board_changed=0 (0 = never)
        int         pause_at;     // strobe index coinciding with a PAUSE (0 = never)
        int         exp_strobes;
        int         exp_gen;
        int         exp_stable;
        int         exp_done;
    } vec_t;

    vec_t vecs[7];

    // Issue LOAD from IDLE; check cell_rst width, cmd_ready low meanwhile, cleared status.
    task automatic do_load();
        int rh = 0;
        int nr = 0;
        int dn = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        check("load_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < LOAD_CYCLES + 3; i++) begin
            if (cell_rst) rh++;
            if (!cmd_ready) nr++;
            if (done) dn++;
            @(negedge clk);
        end
        $display("[TB] LOAD: cell_rst cycles=%0d not-ready cycles=%0d gen=%0d stable=%0d",
                 rh, nr, generation, stable);
        check("load_rst_cycles", rh, LOAD_CYCLES);
        check("load_notready_cycles", nr, LOAD_CYCLES);
        check("load_gen", generation, 0);
        check("load_stable", stable, 0);
        check("load_no_done", dn, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  strobes  = 0;
        int  dones    = 0;
        int  ovl      = 0;
        int  period;
        bit  finished = 1'b0;
        period        = (v.op == 2'b01) ? 1 : TICK_DIV;
        cmd_valid     = 1'b1;
        cmd_op        = v.op;
        cmd_count     = GEN_W'(v.count);
        board_changed = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 300; c++) begin
            if (cell_ena && cell_rst) ovl++;
            if (done) dones++;
            cmd_valid     = 1'b0;
            board_changed = 1'b1;
            if (cell_ena) begin
                strobes++;
                check("strobe_cycle", c, strobes * period);
                if (strobes == v.zero_at) board_changed = 1'b0;
                if (strobes == v.pause_at) begin
                    cmd_valid = 1'b1;
                    cmd_op    = 2'b11;
                end
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("run_finished", finished, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cell_ena) strobes++;
            if (done) dones++;
            if (cell_ena && cell_rst) ovl++;
        end
        $display("[TB] vec %0d op=%0d count=%0d: strobes=%0d gen=%0d stable=%0d dones=%0d",
                 idx, v.op, v.count, strobes, generation, stable, dones);
        check("strobes", strobes, v.exp_strobes);
        check("generation", generation, v.exp_gen);
        check("stable", stable, v.exp_stable);
        check("done_pulses", dones, v.exp_done);
        check("rst_ena_overlap", ovl, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op     cnt zero pause str gen stb done
        vecs[0] = '{2'b01,  0,  0,   0,   1,  1,  0,  1};  // STEP, board changing
        vecs[1] = '{2'b10,  3,  0,   0,   3,  3,  0,  1};  // RUN 3
        vecs[2] = '{2'b10,  0,  0,   5,   5,  5,  0,  0};  // RUN forever, PAUSE on 5th strobe
        vecs[3] = '{2'b10, 10,  2,   0,   2,  2,  1,  1};  // still board at strobe 2
        vecs[4] = '{2'b01,  0,  1,   0,   1,  1,  1,  1};  // STEP on a still board
        vecs[5] = '{2'b10,  1,  0,   0,   1,  1,  0,  1};  // RUN 1
        vecs[6] = '{2'b10,  2,  2,   0,   2,  2,  1,  1};  // count end and still together

        rst_n = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0; board_changed = 1'b1;
        s_cmd_valid = 1'b0; s_cmd_op = 2'b00; s_cmd_count = '0; s_board_changed = 1'b1;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        $display("[TB] reset: cell_rst=%0d cell_ena=%0d cmd_ready=%0d gen=%0d", cell_rst, cell_ena, cmd_ready, generation);
        check("rst_cell_rst", cell_rst, 1);
        check("rst_cell_ena", cell_ena, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_gen", generation, 0);
        check("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rel_ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        $display("[TB] release: cell_rst=%0d cmd_ready=%0d", cell_rst, cmd_ready);
        check("rel_cell_rst", cell_rst, 0);
        check("rel_cmd_ready", cmd_ready, 1);

        // PAUSE in IDLE is dropped
        cmd_valid = 1'b1; cmd_op = 2'b11;
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("[TB] idle PAUSE: busy=%0d", busy);
        check("idle_pause_busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            do_load();
            run_vec(vecs[i], i);
        end
        do_load();  // stable was 1 after vec 6: LOAD must clear it

        // Asynchronous reset in the middle of a RUN
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = '0; board_changed = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_gen_before", generation, 1);
        #2 rst_n = 1'b0;
        #1;
        $display("[TB] mid-run reset: busy=%0d cell_rst=%0d gen=%0d", busy, cell_rst, generation);
        check("midrun_busy", busy, 0);
        check("midrun_cell_rst", cell_rst, 1);
        check("midrun_gen", generation, 0);
        check("midrun_ena", cell_ena, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrun_no_done", done, 0);
        check("midrun_ready", cmd_ready, 1);

        // Saturation on the GEN_W=2 instance
        s_cmd_valid = 1'b1; s_cmd_op = 2'b00;
        @(negedge clk);
        s_cmd_valid = 1'b0;
        check("sat_load_rst", s_cell_rst, 1);
        @(negedge clk);
        check("sat_load_over", s_cell_rst, 0);
        s_cmd_valid = 1'b1; s_cmd_op = 2'b10; s_cmd_count = 2'd0; s_board_changed = 1'b1;
        @(negedge clk);
        s_cmd_valid = 1'b0;
        check("sat_first_strobe", s_cell_ena, 1);
        repeat (2) @(negedge clk);
        check("sat_gen_mid", s_generation, 2);
        repeat (3) @(negedge clk);
        s_cmd_valid = 1'b1; s_cmd_op = 2'b11;
        @(negedge clk);
        s_cmd_valid = 1'b0;
        $display("[TB] saturation: gen=%0d busy=%0d", s_generation, s_busy);
        check("sat_gen", s_generation, 3);
        check("sat_busy", s_busy, 0);
        check("sat_no_done", s_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
